uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLOCK_FREQUENCY, default 27000000, SHALL be the clk frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, SHALL be the serial bit rate in bit/s.
REQ-003 Derived constants SHALL be BAUD_DIVISOR = CLOCK_FREQUENCY / BAUD_RATE (integer divide, 234 at defaults) and HALF_DIVISOR = BAUD_DIVISOR / 2 (117 at defaults).
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-006 Port rx, input, 1 bit, SHALL be the asynchronous serial line: idle high, 8N1, LSB first.
REQ-007 Port ready, input, 1 bit, SHALL be the consumer acknowledge for the held byte.
REQ-008 Port data, output, 8 bits, SHALL be the last good received byte.
REQ-009 Port valid, output, 1 bit, SHALL be high while data holds an unconsumed byte.
REQ-010 Port frame_err, output, 1 bit, SHALL be a one-cycle pulse on a bad stop bit.
REQ-011 Port overrun, output, 1 bit, SHALL be a one-cycle pulse when a good byte is dropped.
REQ-012 Port busy, output, 1 bit, SHALL be high whenever the FSM is not in IDLE.

Function
REQ-013 rx SHALL pass through a two-flop synchronizer (rx_s) before any use; both flops reset to 1.
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP, WAIT_HIGH, and a 16-bit baud counter.
REQ-015 IDLE: when rx_s==0, enter START with counter cleared; otherwise remain in IDLE.
REQ-016 START: after HALF_DIVISOR cycles, sample rx_s; 0 enters DATA with counter and bit index cleared, 1 returns to IDLE as a false start with no output change.
REQ-017 DATA: every BAUD_DIVISOR cycles, sample rx_s into a shift register, LSB first; after the 8th sample, enter STOP.
REQ-018 STOP: after BAUD_DIVISOR cycles, sample rx_s; 1 completes a good byte and returns to IDLE, 0 pulses frame_err and enters WAIT_HIGH.
REQ-019 WAIT_HIGH: remain until rx_s==1, then IDLE, so a break condition does not retrigger start detection.
REQ-020 On a framing error, data and valid SHALL NOT change.
REQ-021 On a good byte with valid==0, or with valid==1 and ready==1 in the same cycle: data is loaded and valid is 1 on the next cycle.
REQ-022 On a good byte with valid==1 and ready==0: the new byte is discarded, overrun pulses for one cycle, and data/valid are unchanged.
REQ-023 When valid==1 and ready==1 with no byte completing, valid SHALL clear on the next cycle; ready while valid==0 SHALL be ignored.
REQ-024 The counter SHALL count 0..N-1 and clear on each sample; it never wraps past BAUD_DIVISOR-1.
REQ-025 From the first clk edge where rx_s==0 in IDLE, the stop sample SHALL occur exactly HALF_DIVISOR + 9*BAUD_DIVISOR cycles later (2223 at defaults).
REQ-026 valid SHALL rise one cycle after the stop sample.

Reset
REQ-027 Asserting rst SHALL immediately force state=IDLE, counter=0, data=0x00, valid=0, frame_err=0, overrun=0, busy=0, and synchronizer flops=1.
REQ-028 Reset mid-frame SHALL abandon the frame; after release, the receiver SHALL resynchronize only on the next falling edge seen in IDLE.

Verification
REQ-029 Send 0xA5 at defaults with ready=0 -> valid rises 2224 cycles after rx_s first low, data=0xA5, frame_err=0.
REQ-030 Send 0x3C then 0x81 with ready held 0 -> data stays 0x3C, valid stays 1, one overrun pulse at the second stop sample.
REQ-031 Send 0x55 with stop bit forced 0, then hold rx low 5000 cycles, then release -> one frame_err pulse, valid stays 0, busy high until rx_s returns high, no second frame.
REQ-032 Pulse rx low for 50 cycles only -> busy rises, returns to IDLE after the half-bit sample, no valid, frame_err, or overrun.
REQ-033 Assert ready in the exact cycle a second byte 0x7E completes while 0x12 is held -> no overrun, data=0x7E, valid stays 1.
REQ-034 Assert rst during bit 4 of a frame -> all outputs reset immediately; a following 0xC3 frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with synchronized input, single-byte holding register and error pulses
module uart_rx #(
    parameter int CLOCK_FREQUENCY = 27000000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       ready,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int BAUD_DIVISOR = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int HALF_DIVISOR = BAUD_DIVISOR / 2;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIVISOR - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_DIVISOR - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic        rx_meta_q, rx_s_q;

    // Two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State, counter, shifter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state: mid-bit sampling, byte hand-off to the holding register, error pulses
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q & ~ready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == BAUD_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    state_d = (bit_q == 3'd7) ? STOP : DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == BAUD_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = IDLE;
                        if (!valid_q || ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WAIT_HIGH: state_d = rx_s_q ? IDLE : WAIT_HIGH;
            default:   state_d = IDLE;
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed checks of uart_rx against a frame-level reference model
module tb_uart_rx;
    localparam int BAUD = 27000000 / 115200;
    localparam int HALF = BAUD / 2;
    // clk edges from driving the start bit to the edge that raises valid (2 sync + half + 9 bits + 1)
    localparam int LAT = 3 + HALF + 9 * BAUD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid, frame_err, overrun, busy;

    int n_checks = 0;
    int n_fail = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int fe0, ov0;

    uart_rx dut (
        .clk(clk), .rst(rst), .rx(rx), .ready(ready),
        .data(data), .valid(valid), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    // Count one-cycle pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; rx = 1'b1; ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Called at a negedge; returns at a negedge with the line high
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int extra_low);
        rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BAUD) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BAUD) @(negedge clk);
        if (!stop_bit) repeat (extra_low) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        apply_reset();
    endtask

    task automatic test_latency();
        apply_reset();
        fe0 = fe_cnt;
        fork
            send_frame(8'hA5, 1'b1, 0);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1;
                n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: valid %b expected 0", valid); end
                @(posedge clk);
                #1;
                n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL latency_rise: valid %b expected 1", valid); end
                n_checks++; if (data !== 8'hA5) begin n_fail++; $display("FAIL latency_data: got %h expected a5", data); end
            end
        join
        repeat (20) @(negedge clk);
        n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL latency_frame_err: got %0d pulses expected 0", fe_cnt - fe0); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        ov0 = ov_cnt;
        send_frame(8'h3C, 1'b1, 0);
        repeat (10) @(negedge clk);
        n_checks++; if (data !== 8'h3C || valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first: data %h valid %b expected 3c 1", data, valid); end
        fork
            send_frame(8'h81, 1'b1, 0);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1;
                n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_ov_early: got %b expected 0", overrun); end
                @(posedge clk);
                #1;
                n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL b2b_ov_pulse: got %b expected 1", overrun); end
                @(posedge clk);
                #1;
                n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_ov_end: got %b expected 0", overrun); end
            end
        join
        repeat (10) @(negedge clk);
        n_checks++; if (data !== 8'h3C || valid !== 1'b1) begin n_fail++; $display("FAIL b2b_hold: data %h valid %b expected 3c 1", data, valid); end
        n_checks++; if (ov_cnt - ov0 !== 1) begin n_fail++; $display("FAIL b2b_ov_count: got %0d expected 1", ov_cnt - ov0); end
    endtask

    task automatic test_frame_error();
        apply_reset();
        fe0 = fe_cnt;
        fork
            send_frame(8'h55, 1'b0, 5000);
            begin
                repeat (LAT + 2500) @(negedge clk);
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_hold: got %b expected 1", busy); end
                n_checks++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d expected 1", fe_cnt - fe0); end
                n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ferr_valid: got %b expected 0", valid); end
            end
        join
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_sync: got %b expected 1", busy); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_release: got %b expected 0", busy); end
        repeat (3000) @(negedge clk);
        n_checks++; if (fe_cnt - fe0 !== 1 || valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL ferr_no_second: pulses %0d valid %b busy %b expected 1 0 0", fe_cnt - fe0, valid, busy);
        end
    endtask

    task automatic test_false_start();
        apply_reset();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rx = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fstart_busy: got %b expected 1", busy); end
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (80) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fstart_idle: got %b expected 0", busy); end
        repeat (2500) @(negedge clk);
        n_checks++; if (valid !== 1'b0 || fe_cnt != fe0 || ov_cnt != ov0) begin
            n_fail++; $display("FAIL fstart_quiet: valid %b fe %0d ov %0d expected 0 0 0", valid, fe_cnt - fe0, ov_cnt - ov0);
        end
    endtask

    task automatic test_ready_collision();
        apply_reset();
        ov0 = ov_cnt;
        send_frame(8'h12, 1'b1, 0);
        repeat (10) @(negedge clk);
        n_checks++; if (data !== 8'h12 || valid !== 1'b1) begin n_fail++; $display("FAIL coll_first: data %h valid %b expected 12 1", data, valid); end
        fork
            send_frame(8'h7E, 1'b1, 0);
            begin
                repeat (LAT - 1) @(posedge clk);
                @(negedge clk);
                ready = 1'b1;
                @(posedge clk);
                #1;
                ready = 1'b0;
                n_checks++; if (data !== 8'h7E || valid !== 1'b1 || overrun !== 1'b0) begin
                    n_fail++; $display("FAIL coll_load: data %h valid %b overrun %b expected 7e 1 0", data, valid, overrun);
                end
            end
        join
        repeat (10) @(negedge clk);
        n_checks++; if (ov_cnt - ov0 !== 0 || valid !== 1'b1) begin n_fail++; $display("FAIL coll_after: ov %0d valid %b expected 0 1", ov_cnt - ov0, valid); end
    endtask

    task automatic test_mid_frame_reset();
        apply_reset();
        fe0 = fe_cnt;
        send_frame(8'h12, 1'b1, 0);
        repeat (10) @(negedge clk);
        fork
            send_frame(8'h0F, 1'b1, 0);
            begin
                repeat (BAUD * 5 + HALF) @(negedge clk);
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mreset_busy_before: got %b expected 1", busy); end
                rst = 1'b1;
                #1;
                n_checks++; if (data !== 8'h00 || valid !== 1'b0 || busy !== 1'b0) begin
                    n_fail++; $display("FAIL mreset_outputs: data %h valid %b busy %b expected 00 0 0", data, valid, busy);
                end
            end
        join
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'hC3, 1'b1, 0);
        repeat (10) @(negedge clk);
        n_checks++; if (data !== 8'hC3 || valid !== 1'b1 || fe_cnt != fe0) begin
            n_fail++; $display("FAIL mreset_next: data %h valid %b fe %0d expected c3 1 0", data, valid, fe_cnt - fe0);
        end
    endtask

    task automatic test_random();
        logic [7:0] d, md;
        logic good, mv;
        int mfe, mov;
        apply_reset();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        md = 8'h00; mv = 1'b0; mfe = 0; mov = 0;
        for (int k = 0; k < 6; k++) begin
            d = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 3) != 0);
            if (!good) mfe++;
            else if (!mv) begin mv = 1'b1; md = d; end
            else mov++;
            send_frame(d, good, 0);
            repeat ($urandom_range(5, 40)) @(negedge clk);
            n_checks++; if (data !== md || valid !== mv) begin n_fail++; $display("FAIL rand_byte%0d: data %h valid %b expected %h %b", k, data, valid, md, mv); end
            n_checks++; if (fe_cnt - fe0 != mfe || ov_cnt - ov0 != mov) begin
                n_fail++; $display("FAIL rand_err%0d: fe %0d ov %0d expected %0d %0d", k, fe_cnt - fe0, ov_cnt - ov0, mfe, mov);
            end
            if ($urandom_range(0, 1) == 1) begin
                ready = 1'b1;
                @(negedge clk);
                ready = 1'b0;
                mv = 1'b0;
            end
            repeat (2) @(negedge clk);
            n_checks++; if (valid !== mv) begin n_fail++; $display("FAIL rand_consume%0d: valid %b expected %b", k, valid, mv); end
        end
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_latency();
        test_back_to_back();
        test_frame_error();
        test_false_start();
        test_ready_collision();
        test_mid_frame_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
